seq_alu: RTL

Multi-cycle 16-bit ALU sitting directly downstream of the control unit (CU). It consumes ALUOP/ALU_A/ALU_B on an ALU_Start pulse and returns ALU_Result with a one-cycle ALU_Done pulse. ADD and SUB complete in one cycle. MUL is an iterative shift-add and DIV is an iterative restoring divide, so the CU's wait-for-Done loop has real latency to handle.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/seq_alu_if.sv | 31 +++
 rtl/seq_divider.sv | 55 +++++
 rtl/seq_alu.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and defaults for the sequential ALU
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } alu_state_e;

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - CU <-> ALU request/response bundle (optional flags: SEQ_ALU_FLAGS_EN)
interface seq_alu_if #(parameter int WIDTH = alu_pkg::DEFAULT_WIDTH);

    logic [1:0]       ALUOP;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic             ALU_Start;
    logic [WIDTH-1:0] ALU_Result;
    logic             ALU_Done;
    logic             ALU_Busy;
`ifdef SEQ_ALU_FLAGS_EN
    logic [1:0]       ALU_Flags;
`endif

    modport master (
        output ALUOP, ALU_A, ALU_B, ALU_Start,
`ifdef SEQ_ALU_FLAGS_EN
        input  ALU_Flags,
`endif
        input  ALU_Result, ALU_Done, ALU_Busy
    );

    modport slave (
        input  ALUOP, ALU_A, ALU_B, ALU_Start,
`ifdef SEQ_ALU_FLAGS_EN
        output ALU_Flags,
`endif
        output ALU_Result, ALU_Done, ALU_Busy
    );

endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring-division datapath, one quotient bit per step
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient_next
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;

    // Load operands, or shift in the next dividend bit and try subtracting the divisor.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = WIDTH'(shifted - {1'b0, dvs_q});
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Remainder, quotient and divisor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_next = quo_d;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle 16-bit ALU (ADD/SUB 1 cycle, MUL/DIV iterative); optional SEQ_ALU_FLAGS_EN
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ITER_W = 5
) (
    input  logic     Clock,
    input  logic     Reset,
    seq_alu_if.slave alu
);

    alu_state_e       state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] res_val;
    logic [WIDTH-1:0] quo_next;
    logic             complete;
    logic             div_load;
    logic             div_step;
    logic             last_iter;

    assign last_iter = (cnt_q == ITER_W'(WIDTH - 1));

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk           (Clock),
        .rst           (Reset),
        .load          (div_load),
        .step          (div_step),
        .dividend      (alu.ALU_A),
        .divisor       (alu.ALU_B),
        .quotient_next (quo_next)
    );

    // Next-state and datapath control; completion writes the result register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_val  = '0;
        complete = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (alu.ALU_Start) begin
                    case (alu_op_e'(alu.ALUOP))
                        ALU_ADD: begin
                            res_val  = alu.ALU_A + alu.ALU_B;
                            complete = 1'b1;
                            state_d  = DONE;
                        end
                        ALU_SUB: begin
                            res_val  = alu.ALU_A - alu.ALU_B;
                            complete = 1'b1;
                            state_d  = DONE;
                        end
                        ALU_MUL: begin
                            mcand_d  = alu.ALU_A;
                            mplier_d = alu.ALU_B;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = MUL;
                        end
                        ALU_DIV: begin
                            if (alu.ALU_B == '0) begin
                                res_val  = '0;
                                complete = 1'b1;
                                state_d  = DONE;
                            end else begin
                                div_load = 1'b1;
                                cnt_d    = '0;
                                state_d  = DIV;
                            end
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    res_val  = acc_d;
                    complete = 1'b1;
                    state_d  = DONE;
                end
            end
            DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    res_val  = quo_next;
                    complete = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        result_d = complete ? res_val : result_q;
    end

    // State, counter and multiplier registers; reset aborts any operation.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign alu.ALU_Result = result_q;
    assign alu.ALU_Done   = (state_q == DONE);
    assign alu.ALU_Busy   = (state_q == MUL) || (state_q == DIV);

`ifdef SEQ_ALU_FLAGS_EN
    logic [1:0] flags_q, flags_d;
    logic       dbz;

    assign dbz = ((state_q == IDLE) || (state_q == DONE)) &&
                 (alu_op_e'(alu.ALUOP) == ALU_DIV) && (alu.ALU_B == '0);

    // Zero/DivByZero captured alongside each completed result.
    always_comb begin
        flags_d = flags_q;
        if (complete) begin
            flags_d = {dbz, (res_val == '0)};
        end
    end

    // Flag register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign alu.ALU_Flags = flags_q;
`endif

endmodule
